// File: rtl/reg_write_port.sv
// reg_write_port
//   Write side of the 32x32 register file. A write-back strobe updates one of
//   registers 1..31 (register 0 is hard-wired to zero). All registers are
//   exposed as one flattened bus for the read-port multiplexers. A per-register
//   pending scoreboard and an accepted-write counter let issue logic detect
//   write-after-write hazards before dispatch.
//
// Ports
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset
//   wr_en       write-back strobe
//   wr_addr     write-back destination register
//   wr_data     write-back data
//   issue_en    request to mark issue_addr pending
//   issue_addr  destination register of the issuing instruction
//   issue_busy  combinational: issue request rejected (WAW hazard)
//   regs_flat   register i at bits [WIDTH*i +: WIDTH]
//   pending     scoreboard, bit i = register i has an outstanding producer
//   wr_count    accepted writes to registers 1..31, modulo 2^CNT_W
//
// Issue handshake: issue_en acts as valid and ~issue_busy as ready. An issue
// is accepted on a rising edge where issue_en=1 and issue_busy=0. While
// issue_busy=1 nothing changes and the issuer holds issue_en/issue_addr
// stable and retries on a later cycle.

module reg_write_port #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [4:0]          wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                issue_en,
  input  logic [4:0]          issue_addr,
  output logic                issue_busy,
  output logic [32*WIDTH-1:0] regs_flat,
  output logic [31:0]         pending,
  output logic [CNT_W-1:0]    wr_count
);

  // One-hot decodes for registers 1..31. Address 0 has no storage and can
  // never be pending, so its decoder output is simply not produced.
  logic [31:1] wr_dec;
  logic [31:1] issue_dec;

  always_comb begin
    wr_dec    = '0;
    issue_dec = '0;
    for (int i = 1; i < 32; i++) begin
      wr_dec[i]    = wr_en    && (wr_addr    == 5'(i));
      issue_dec[i] = issue_en && (issue_addr == 5'(i));
    end
  end

  // A write-back to the same register in the same cycle retires the old
  // producer, so the new issue is not a hazard.
  logic same_reg_wb;
  assign same_reg_wb = wr_en && (wr_addr == issue_addr);

  assign issue_busy = issue_en && (issue_addr != 5'd0) &&
                      pending[issue_addr] && !same_reg_wb;

  // Register 0: always zero, never pending.
  assign regs_flat[WIDTH-1:0] = '0;
  assign pending[0]           = 1'b0;

  logic [31:1] pending_q;

  for (genvar g = 1; g < 32; g++) begin : g_reg
    logic [WIDTH-1:0] data_q;
    logic             set_term;
    logic             clr_term;

    assign set_term = issue_dec[g] && !issue_busy;
    assign clr_term = wr_dec[g];

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        data_q <= '0;
      end else if (wr_dec[g]) begin
        data_q <= wr_data;
      end
    end

    // Set has priority over clear: a new producer replaces the retiring one.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        pending_q[g] <= 1'b0;
      end else if (set_term) begin
        pending_q[g] <= 1'b1;
      end else if (clr_term) begin
        pending_q[g] <= 1'b0;
      end
    end

    assign regs_flat[WIDTH*g +: WIDTH] = data_q;
    assign pending[g]                  = pending_q[g];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_count <= '0;
    end else if (wr_en && (wr_addr != 5'd0)) begin
      wr_count <= wr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_reg_write_port.sv
module tb_reg_write_port;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  logic                clock;
  logic                reset_n;
  logic                wr_en;
  logic [4:0]          wr_addr;
  logic [WIDTH-1:0]    wr_data;
  logic                issue_en;
  logic [4:0]          issue_addr;
  logic                issue_busy;
  logic [32*WIDTH-1:0] regs_flat;
  logic [31:0]         pending;
  logic [CNT_W-1:0]    wr_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] exp_q[$];

  reg_write_port #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .issue_busy (issue_busy),
    .regs_flat  (regs_flat),
    .pending    (pending),
    .wr_count   (wr_count)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge; return 1 time unit after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] reg_at(input int i);
    return regs_flat[WIDTH*i +: WIDTH];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle();
    wr_en      = 1'b0;
    wr_addr    = 5'd0;
    wr_data    = '0;
    issue_en   = 1'b0;
    issue_addr = 5'd0;
  endtask

  task automatic drive_write(input logic [4:0] a, input logic [WIDTH-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic drive_issue(input logic [4:0] a);
    issue_en   = 1'b1;
    issue_addr = a;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    #3;
    n_checks++;
    if (pending !== 32'h0) begin
      n_fail++; $display("FAIL reset_pending: got %h want %h", pending, 32'h0);
    end
    n_checks++;
    if (wr_count !== 16'h0) begin
      n_fail++; $display("FAIL reset_count: got %h want %h", wr_count, 16'h0);
    end
    n_checks++;
    if (regs_flat !== '0) begin
      n_fail++; $display("FAIL reset_regs: regs_flat not all zero");
    end
    #4 reset_n = 1'b1;  // released away from the edge at t=5
    // Load r5 and mark r6 pending in the first cycle after release.
    drive_write(5'd5, 32'hDEADBEEF);
    drive_issue(5'd6);
    step();
    idle();
    n_checks++;
    if (reg_at(5) !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL load_r5: got %h want %h", reg_at(5), 32'hDEADBEEF);
    end
    n_checks++;
    if (pending !== 32'h0000_0040) begin
      n_fail++; $display("FAIL pending_r6: got %h want %h", pending, 32'h0000_0040);
    end
    // Assert reset mid-cycle with a write in flight: clears without an edge.
    drive_write(5'd5, 32'h1234_5678);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (reg_at(5) !== 32'h0) begin
      n_fail++; $display("FAIL async_r5: got %h want %h", reg_at(5), 32'h0);
    end
    n_checks++;
    if (pending !== 32'h0) begin
      n_fail++; $display("FAIL async_pending: got %h want %h", pending, 32'h0);
    end
    n_checks++;
    if (wr_count !== 16'h0) begin
      n_fail++; $display("FAIL async_count: got %h want %h", wr_count, 16'h0);
    end
    // Hold reset across an edge with wr_en/issue_en active: ignored.
    drive_issue(5'd8);
    step();
    n_checks++;
    if (reg_at(5) !== 32'h0 || pending !== 32'h0 || wr_count !== 16'h0) begin
      n_fail++; $display("FAIL reset_hold: r5=%h pending=%h count=%h want all 0",
                         reg_at(5), pending, wr_count);
    end
    idle();
    reset_n = 1'b1;
  endtask

  task automatic test_decode_sweep();
    for (int i = 0; i < 32; i++) begin
      drive_write(5'(i), 32'h1000_0000 + i);
      exp_q.push_back(i == 0 ? 32'h0 : 32'h1000_0000 + i);
      step();
    end
    idle();
    for (int i = 0; i < 32; i++) begin
      logic [WIDTH-1:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (reg_at(i) !== e) begin
        n_fail++; $display("FAIL sweep_r%0d: got %h want %h", i, reg_at(i), e);
      end
    end
    n_checks++;
    if (wr_count !== 16'd31) begin
      n_fail++; $display("FAIL sweep_count: got %0d want %0d", wr_count, 31);
    end
  endtask

  task automatic test_scoreboard();
    drive_issue(5'd7);
    #1;
    n_checks++;
    if (issue_busy !== 1'b0) begin
      n_fail++; $display("FAIL sb_first_busy: got %b want 0", issue_busy);
    end
    step();
    n_checks++;
    if (pending !== 32'h0000_0080) begin
      n_fail++; $display("FAIL sb_set7: got %h want %h", pending, 32'h0000_0080);
    end
    // Second issue to r7 is a WAW hazard: rejected, no state change.
    #1;
    n_checks++;
    if (issue_busy !== 1'b1) begin
      n_fail++; $display("FAIL sb_busy7: got %b want 1", issue_busy);
    end
    step();
    n_checks++;
    if (pending !== 32'h0000_0080) begin
      n_fail++; $display("FAIL sb_hold7: got %h want %h", pending, 32'h0000_0080);
    end
    idle();
    drive_write(5'd7, 32'h55);
    step();
    idle();
    n_checks++;
    if (pending !== 32'h0) begin
      n_fail++; $display("FAIL sb_clr7: got %h want %h", pending, 32'h0);
    end
    n_checks++;
    if (reg_at(7) !== 32'h55) begin
      n_fail++; $display("FAIL sb_r7: got %h want %h", reg_at(7), 32'h55);
    end
    n_checks++;
    if (wr_count !== 16'd32) begin
      n_fail++; $display("FAIL sb_count: got %0d want %0d", wr_count, 32);
    end
  endtask

  task automatic test_same_reg();
    drive_issue(5'd3);
    step();
    drive_write(5'd3, 32'hA5);
    #1;
    n_checks++;
    if (issue_busy !== 1'b0) begin
      n_fail++; $display("FAIL same_busy: got %b want 0", issue_busy);
    end
    // Without the write the same issue would be busy.
    wr_en = 1'b0;
    #1;
    n_checks++;
    if (issue_busy !== 1'b1) begin
      n_fail++; $display("FAIL same_nowb_busy: got %b want 1", issue_busy);
    end
    wr_en = 1'b1;
    step();
    idle();
    n_checks++;
    if (pending !== 32'h0000_0008) begin
      n_fail++; $display("FAIL same_pending: got %h want %h", pending, 32'h0000_0008);
    end
    n_checks++;
    if (reg_at(3) !== 32'hA5) begin
      n_fail++; $display("FAIL same_r3: got %h want %h", reg_at(3), 32'hA5);
    end
  endtask

  task automatic test_reg0();
    drive_issue(5'd0);
    #1;
    n_checks++;
    if (issue_busy !== 1'b0) begin
      n_fail++; $display("FAIL r0_busy: got %b want 0", issue_busy);
    end
    step();
    idle();
    n_checks++;
    if (pending !== 32'h0000_0008) begin
      n_fail++; $display("FAIL r0_pending: got %h want %h", pending, 32'h0000_0008);
    end
    drive_write(5'd0, 32'hFFFF_FFFF);
    step();
    idle();
    n_checks++;
    if (reg_at(0) !== 32'h0) begin
      n_fail++; $display("FAIL r0_data: got %h want %h", reg_at(0), 32'h0);
    end
    n_checks++;
    if (wr_count !== 16'd33) begin
      n_fail++; $display("FAIL r0_count: got %0d want %0d", wr_count, 33);
    end
  endtask

  task automatic test_independent();
    drive_issue(5'd4);
    step();
    drive_issue(5'd12);
    drive_write(5'd4, 32'h44);
    step();
    idle();
    n_checks++;
    if (pending !== 32'h0000_1008) begin
      n_fail++; $display("FAIL indep_pending: got %h want %h", pending, 32'h0000_1008);
    end
    n_checks++;
    if (reg_at(4) !== 32'h44) begin
      n_fail++; $display("FAIL indep_r4: got %h want %h", reg_at(4), 32'h44);
    end
  endtask

  task automatic test_back_to_back();
    drive_write(5'd9, 32'h111);
    #1;
    // No bypass: old value visible during the write cycle.
    n_checks++;
    if (reg_at(9) !== 32'h1000_0009) begin
      n_fail++; $display("FAIL b2b_nobypass: got %h want %h", reg_at(9), 32'h1000_0009);
    end
    step();
    drive_write(5'd9, 32'h222);
    step();
    idle();
    n_checks++;
    if (reg_at(9) !== 32'h222) begin
      n_fail++; $display("FAIL b2b_last: got %h want %h", reg_at(9), 32'h222);
    end
    n_checks++;
    if (wr_count !== 16'd36) begin
      n_fail++; $display("FAIL b2b_count: got %0d want %0d", wr_count, 36);
    end
  endtask

  task automatic test_wrap();
    // 36 writes accepted so far; 65499 more reach 0xFFFF.
    drive_write(5'd9, 32'h9999);
    repeat (65499) @(posedge clock);
    #1;
    wr_en = 1'b0;
    n_checks++;
    if (wr_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL wrap_pre: got %h want %h", wr_count, 16'hFFFF);
    end
    drive_write(5'd9, 32'h9A9A);
    step();
    idle();
    n_checks++;
    if (wr_count !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_zero: got %h want %h", wr_count, 16'h0000);
    end
    n_checks++;
    if (reg_at(9) !== 32'h9A9A) begin
      n_fail++; $display("FAIL wrap_r9: got %h want %h", reg_at(9), 32'h9A9A);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    reset_n = 1'b0;
    idle();
    test_reset();
    test_decode_sweep();
    test_scoreboard();
    test_same_reg();
    test_reg0();
    test_independent();
    test_back_to_back();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
